// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler that shares one UART txlogic among
// NUM_REQ byte producers, one byte at a time.
// Build option: define UART_ARB_LOCK_EN to add req_lock, which lets the last
// granted requester keep the transmitter for multi-byte messages.
//
// Handshake semantics: byte i moves from requester i into the arbiter on a
// rising edge where req_valid[i] && req_ready[i]. req_ready is one-hot, is only
// raised in IDLE while txlogic reports rdy_4_data, and never depends on
// req_ready itself, so a requester may raise or drop req_valid at any time.
// Toward txlogic, tx_data_valid is a registered one-cycle pulse. Acceptance is
// inferred from rdy_4_data falling or transmitting rising. The frame is
// complete once rdy_4_data is high again with transmitting low.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int GNT_W   = 2,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
`ifdef UART_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]   req_lock,
`endif
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data_in,
    output logic                 tx_data_valid,
    input  logic                 tx_rdy_4_data,
    input  logic                 tx_transmitting,
    output logic [GNT_W-1:0]     grant_id,
    output logic                 busy,
    output logic [CNT_W-1:0]     byte_cnt,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_ACK  = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [GNT_W-1:0] rr_ptr;
    logic [GNT_W-1:0] winner;
    logic             win_found;
    logic             accept;
    int               scan_idx;

    // Winner search: first valid requester after the last winner, wrapping.
    always_comb begin
        winner    = '0;
        win_found = 1'b0;
        scan_idx  = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx = int'(rr_ptr) + k;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            if (!win_found && req_valid[scan_idx]) begin
                winner    = GNT_W'(scan_idx);
                win_found = 1'b1;
            end
        end
`ifdef UART_ARB_LOCK_EN
        // A locked, still-valid previous owner keeps the transmitter.
        if (req_lock[grant_id] && req_valid[grant_id]) begin
            winner    = grant_id;
            win_found = 1'b1;
        end
`endif
    end

    // Accept strobe: one-hot ready to the winner while idle and txlogic is ready.
    always_comb begin
        accept    = (state == S_IDLE) && tx_rdy_4_data && win_found;
        req_ready = '0;
        if (accept) begin
            req_ready[winner] = 1'b1;
        end
    end

    // Next-state logic for the issue / wait-for-txlogic sequence.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_nxt = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (!tx_rdy_4_data || tx_transmitting) begin
                    state_nxt = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (tx_rdy_4_data && !tx_transmitting) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath: capture the winning byte, pulse data_valid, count issued bytes.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data_in    <= 8'h00;
            tx_data_valid <= 1'b0;
            grant_id      <= '0;
            rr_ptr        <= GNT_W'(NUM_REQ - 1);
            byte_cnt      <= '0;
        end else begin
            tx_data_valid <= accept;
            if (accept) begin
                tx_data_in <= req_data[8*winner +: 8];
                grant_id   <= winner;
                rr_ptr     <= winner;
            end
            if (state == S_ISSUE) begin
                byte_cnt <= byte_cnt + CNT_W'(1);
            end
        end
    end

    // Status outputs.
    always_comb begin
        busy      = (state != S_IDLE);
        state_dbg = state;
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized bench for uart_tx_arbiter with a txlogic model
// and a round-robin reference model. Define UART_ARB_LOCK_EN to also cover req_lock.
module tb_uart_tx_arbiter;
    localparam int NR = 4;
    localparam int GW = 2;
    localparam int CW = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [NR-1:0]   req_valid = '0;
    logic [8*NR-1:0] req_data  = '0;
    logic [NR-1:0]   lock_vec;
`ifdef UART_ARB_LOCK_EN
    logic [NR-1:0]   req_lock  = '0;
    assign lock_vec = req_lock;
`else
    assign lock_vec = '0;
`endif
    logic [NR-1:0] req_ready;
    logic [7:0]    tx_data_in;
    logic          tx_data_valid;
    logic          tx_rdy_4_data   = 1'b1;
    logic          tx_transmitting = 1'b0;
    logic [GW-1:0] grant_id;
    logic          busy;
    logic [CW-1:0] byte_cnt;
    logic [1:0]    state_dbg;

    uart_tx_arbiter #(.NUM_REQ(NR), .GNT_W(GW), .CNT_W(CW)) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_data(req_data),
`ifdef UART_ARB_LOCK_EN
        .req_lock(req_lock),
`endif
        .req_ready(req_ready),
        .tx_data_in(tx_data_in),
        .tx_data_valid(tx_data_valid),
        .tx_rdy_4_data(tx_rdy_4_data),
        .tx_transmitting(tx_transmitting),
        .grant_id(grant_id),
        .busy(busy),
        .byte_cnt(byte_cnt),
        .state_dbg(state_dbg)
    );

    // ---------------- shared state ----------------
    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];     // bytes expected on tx_data_in, in order
    int         expg_q[$];    // grant_id expected alongside each byte
    logic [7:0] sent_q[$];    // every accepted byte
    logic [7:0] serial_q[$];  // every byte the txlogic model took
    int         acc_hist[$];  // index of every accepted requester
    int         last_rr    = NR - 1;
    int         last_grant = 0;
    bit         pend       = 1'b0;
    int         acc_cyc    = 0;
    int         bytes_rst  = 0;

    bit model_en = 1'b1;
    int hold_len = 0;
    int tx_cnt   = 0;

    int rem[NR];
    bit rand_data = 1'b0;
    bit drop_en   = 1'b0;
    int n_done    = 0;

    int         mw;
    int         maw;
    logic [NR-1:0] m_exp;

    // Reference arbitration: lowest rotational distance past the last winner,
    // unless a locked, valid previous owner keeps the grant.
    function automatic int pick(input logic [NR-1:0] v, input logic [NR-1:0] lk);
        int best;
        int best_d;
        int d;
        best   = -1;
        best_d = NR;
        if (lk[last_grant] && v[last_grant]) return last_grant;
        for (int i = 0; i < NR; i++) begin
            d = (i - last_rr - 1 + 2 * NR) % NR;
            if (v[i] && d < best_d) begin
                best   = i;
                best_d = d;
            end
        end
        return best;
    endfunction

    // ---------------- txlogic model ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (!model_en) begin
                tx_cnt          = 0;
                tx_rdy_4_data   = 1'b1;
                tx_transmitting = 1'b0;
            end else if (tx_cnt > 0) begin
                tx_cnt--;
                if (tx_cnt == 0) begin
                    tx_rdy_4_data   = 1'b1;
                    tx_transmitting = 1'b0;
                end
            end else if (tx_data_valid === 1'b1 && tx_rdy_4_data) begin
                serial_q.push_back(tx_data_in);
                tx_rdy_4_data   = 1'b0;
                tx_transmitting = 1'b1;
                tx_cnt = (hold_len > 0) ? hold_len : int'($urandom_range(2, 12));
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                last_rr    = NR - 1;
                last_grant = 0;
                exp_q.delete();
                expg_q.delete();
                pend      = 1'b0;
                bytes_rst = 0;
            end else begin
                if (pend && cyc == acc_cyc + 1) begin
                    checks++;
                    if (tx_data_valid !== 1'b1 || tx_data_in !== exp_q[0] ||
                        grant_id !== GW'(expg_q[0])) begin
                        errors++;
                        $display("FAIL issue: valid=%b data=%h grant=%0d required valid=1 data=%h grant=%0d",
                                 tx_data_valid, tx_data_in, grant_id, exp_q[0], expg_q[0]);
                    end
                    void'(exp_q.pop_front());
                    void'(expg_q.pop_front());
                    pend = 1'b0;
                end else begin
                    checks++;
                    if (tx_data_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL spurious_valid: tx_data_valid=%b required 0 (cycle %0d)",
                                 tx_data_valid, cyc);
                    end
                end
                if (req_ready !== '0) begin
                    mw    = pick(req_valid, lock_vec);
                    m_exp = (mw >= 0 && tx_rdy_4_data) ? NR'(1 << mw) : '0;
                    checks++;
                    if (req_ready !== m_exp) begin
                        errors++;
                        $display("FAIL req_ready: got %b required %b (valid=%b)",
                                 req_ready, m_exp, req_valid);
                    end
                    maw = -1;
                    for (int i = NR - 1; i >= 0; i--) begin
                        if (req_ready[i] && req_valid[i]) maw = i;
                    end
                    if (maw >= 0) begin
                        exp_q.push_back(req_data[8*maw +: 8]);
                        expg_q.push_back(maw);
                        sent_q.push_back(req_data[8*maw +: 8]);
                        acc_hist.push_back(maw);
                        acc_cyc    = cyc;
                        pend       = 1'b1;
                        bytes_rst  = bytes_rst + 1;
                        last_rr    = maw;
                        last_grant = maw;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
        while (n_done < acc_hist.size()) begin
            int w;
            w = acc_hist[n_done];
            n_done++;
            if (rem[w] > 0) rem[w]--;
            if (rem[w] == 0) req_valid[w] = 1'b0;
            else if (rand_data) req_data[8*w +: 8] = 8'($urandom);
        end
        if (drop_en) begin
            for (int i = 0; i < NR; i++) begin
                if (rem[i] > 0 && $urandom_range(0, 7) == 0) req_valid[i] = ~req_valid[i];
            end
        end
    endtask

    function automatic bit quiet();
        bit q;
        q = (busy === 1'b0) && (tx_cnt == 0) && (n_done == acc_hist.size()) && !pend;
        for (int i = 0; i < NR; i++) if (rem[i] != 0) q = 1'b0;
        return q;
    endfunction

    task automatic wait_acc(input int target, input int budget, output bit ok);
        int n;
        n = 0;
        while (acc_hist.size() < target && n < budget) begin
            step();
            n++;
        end
        ok = (acc_hist.size() >= target);
    endtask

    task automatic wait_quiet(input int budget, output bit ok);
        int n;
        n = 0;
        while (!quiet() && n < budget) begin
            step();
            n++;
        end
        ok = quiet();
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        for (int i = 0; i < NR; i++) rem[i] = 0;
        hold_len  = 0;
        rand_data = 1'b0;
        drop_en   = 1'b0;
`ifdef UART_ARB_LOCK_EN
        req_lock  = '0;
`endif
        step();
        step();
        n_done = acc_hist.size();
        rst    = 1'b0;
        step();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (tx_data_valid !== 1'b0 || tx_data_in !== 8'h00) begin
            errors++;
            $display("FAIL reset_tx: valid=%b data=%h required 0/00", tx_data_valid, tx_data_in);
        end
        checks++;
        if (grant_id !== '0 || byte_cnt !== '0) begin
            errors++;
            $display("FAIL reset_cnt: grant=%0d cnt=%0d required 0/0", grant_id, byte_cnt);
        end
        rst = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || req_ready !== '0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b ready=%b required 0/0000", busy, req_ready);
        end
    endtask

    task automatic test_first_byte();
        bit ok;
        int sb;
        do_reset();
        sb = serial_q.size();
        req_data[7:0] = 8'h88;
        rem[0]        = 1;
        req_valid     = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL first_ready: got %b required 0001", req_ready);
        end
        step();
        checks++;
        if (tx_data_valid !== 1'b1 || tx_data_in !== 8'h88 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL first_issue: valid=%b data=%h grant=%0d required 1/88/0",
                     tx_data_valid, tx_data_in, grant_id);
        end
        checks++;
        if (req_ready !== '0) begin
            errors++;
            $display("FAIL first_ready_drop: got %b required 0000", req_ready);
        end
        step();
        checks++;
        if (byte_cnt !== 16'd1) begin
            errors++;
            $display("FAIL first_cnt: got %0d required 1", byte_cnt);
        end
        wait_quiet(200, ok);
        checks++;
        if (!ok || serial_q.size() != sb + 1 || serial_q[sb] !== 8'h88) begin
            errors++;
            $display("FAIL first_serial: quiet=%b count=%0d required quiet with 1 byte 88",
                     ok, serial_q.size() - sb);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        int sb;
        int hb;
        logic [7:0] exp_b[4];
        exp_b = '{8'h88, 8'h44, 8'h22, 8'h11};
        do_reset();
        sb       = serial_q.size();
        hb       = acc_hist.size();
        req_data = 32'h11224488;
        for (int i = 0; i < NR; i++) rem[i] = 2;
        req_valid = 4'b1111;
        wait_quiet(1000, ok);
        checks++;
        if (!ok || acc_hist.size() != hb + 8 || serial_q.size() != sb + 8) begin
            errors++;
            $display("FAIL rr_count: quiet=%b grants=%0d bytes=%0d required 8/8",
                     ok, acc_hist.size() - hb, serial_q.size() - sb);
        end else begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (acc_hist[hb+k] != k % NR || serial_q[sb+k] !== exp_b[k%NR]) begin
                    errors++;
                    $display("FAIL rr_order[%0d]: grant=%0d byte=%h required %0d/%h",
                             k, acc_hist[hb+k], serial_q[sb+k], k % NR, exp_b[k%NR]);
                end
            end
        end
    endtask

    task automatic test_hold();
        bit ok;
        int held;
        int bad;
        int n;
        do_reset();
        rand_data        = 1'b1;
        req_data[15:8]   = 8'($urandom);
        rem[1]           = 2;
        req_valid        = 4'b0010;
        hold_len         = 500;
        n = 0;
        while (tx_cnt == 0 && n < 20) begin
            step();
            n++;
        end
        hold_len = 0;
        checks++;
        if (tx_cnt == 0) begin
            errors++;
            $display("FAIL hold_start: txlogic never received a byte within %0d cycles", n);
        end
        held = 0;
        bad  = 0;
        while (tx_cnt > 0 && held < 700) begin
            if (busy !== 1'b1 || req_ready !== '0) bad++;
            step();
            held++;
        end
        checks++;
        if (bad != 0 || held < 499) begin
            errors++;
            $display("FAIL hold_wait: violations=%0d held=%0d required 0 and >=499", bad, held);
        end
        wait_quiet(200, ok);
        checks++;
        if (!ok || byte_cnt !== CW'(bytes_rst) || bytes_rst != 2) begin
            errors++;
            $display("FAIL hold_resume: quiet=%b cnt=%0d required 2", ok, byte_cnt);
        end
    endtask

    task automatic test_skip();
        bit ok;
        int hb;
        int exp_g[5];
        exp_g = '{1, 3, 1, 3, 1};
        do_reset();
        hb        = acc_hist.size();
        rand_data = 1'b1;
        req_data  = $urandom;
        rem[1]    = 1;
        req_valid = 4'b0010;
        wait_quiet(200, ok);
        rem[1]    = 2;
        rem[3]    = 2;
        req_valid = 4'b1010;
        wait_quiet(500, ok);
        checks++;
        if (!ok || acc_hist.size() != hb + 5) begin
            errors++;
            $display("FAIL skip_count: quiet=%b grants=%0d required 5", ok, acc_hist.size() - hb);
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (acc_hist[hb+k] != exp_g[k]) begin
                    errors++;
                    $display("FAIL skip_order[%0d]: got %0d required %0d", k, acc_hist[hb+k], exp_g[k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int hb;
        do_reset();
        model_en       = 1'b0;
        step();
        hb             = acc_hist.size();
        req_data[23:16] = 8'h5A;
        rem[2]         = 1;
        req_valid      = 4'b0100;
        wait_acc(hb + 1, 20, ok);
        checks++;
        if (!ok || tx_data_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_issue: accepted=%b valid=%b required 1/1", ok, tx_data_valid);
        end
        step();
        step();
        checks++;
        if (busy !== 1'b1 || tx_data_valid !== 1'b0 || grant_id !== 2'd2) begin
            errors++;
            $display("FAIL mid_wait: busy=%b valid=%b grant=%0d required 1/0/2",
                     busy, tx_data_valid, grant_id);
        end
        rst = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || tx_data_valid !== 1'b0 || byte_cnt !== '0 || grant_id !== '0) begin
            errors++;
            $display("FAIL mid_reset: busy=%b valid=%b cnt=%0d grant=%0d required 0/0/0/0",
                     busy, tx_data_valid, byte_cnt, grant_id);
        end
        rst      = 1'b0;
        model_en = 1'b1;
        step();
        hb        = acc_hist.size();
        rand_data = 1'b1;
        req_data  = $urandom;
        for (int i = 0; i < NR; i++) rem[i] = 1;
        req_valid = 4'b1111;
        wait_quiet(500, ok);
        checks++;
        if (!ok || acc_hist.size() != hb + 4 || acc_hist[hb] != 0 || byte_cnt !== 16'd4) begin
            errors++;
            $display("FAIL mid_restart: quiet=%b first=%0d cnt=%0d required first 0 cnt 4",
                     ok, (acc_hist.size() > hb) ? acc_hist[hb] : -1, byte_cnt);
        end
    endtask

    task automatic test_random();
        bit ok;
        int sb;
        int tb;
        do_reset();
        for (int r = 0; r < 6; r++) begin
            sb        = serial_q.size();
            tb        = sent_q.size();
            rand_data = 1'b1;
            drop_en   = 1'b1;
            for (int i = 0; i < NR; i++) begin
                rem[i]             = $urandom_range(0, 4);
                req_valid[i]       = (rem[i] > 0);
                req_data[8*i +: 8] = 8'($urandom);
            end
            wait_quiet(3000, ok);
            drop_en = 1'b0;
            checks++;
            if (!ok || serial_q.size() - sb != sent_q.size() - tb) begin
                errors++;
                $display("FAIL rand_done[%0d]: quiet=%b serial=%0d sent=%0d", r, ok,
                         serial_q.size() - sb, sent_q.size() - tb);
            end else begin
                for (int k = 0; k < serial_q.size() - sb; k++) begin
                    checks++;
                    if (serial_q[sb+k] !== sent_q[tb+k]) begin
                        errors++;
                        $display("FAIL rand_byte[%0d.%0d]: got %h required %h", r, k,
                                 serial_q[sb+k], sent_q[tb+k]);
                    end
                end
            end
            checks++;
            if (byte_cnt !== CW'(bytes_rst)) begin
                errors++;
                $display("FAIL rand_cnt[%0d]: got %0d required %0d", r, byte_cnt, bytes_rst);
            end
        end
    endtask

`ifdef UART_ARB_LOCK_EN
    task automatic test_lock();
        bit ok;
        int hb;
        int exp_g[4];
        exp_g = '{2, 2, 2, 3};
        do_reset();
        hb        = acc_hist.size();
        rand_data = 1'b1;
        req_data  = $urandom;
        req_lock  = 4'b0100;
        rem[2]    = 10;
        rem[3]    = 5;
        req_valid = 4'b1100;
        wait_acc(hb + 3, 300, ok);
        req_lock = '0;
        wait_acc(hb + 4, 300, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL lock_count: grants=%0d required 4", acc_hist.size() - hb);
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (acc_hist[hb+k] != exp_g[k]) begin
                    errors++;
                    $display("FAIL lock_order[%0d]: got %0d required %0d", k, acc_hist[hb+k], exp_g[k]);
                end
            end
        end
        for (int i = 0; i < NR; i++) rem[i] = 0;
        req_valid = '0;
        wait_quiet(300, ok);
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        for (int i = 0; i < NR; i++) rem[i] = 0;
        test_reset();
        test_first_byte();
        test_round_robin();
        test_hold();
        test_skip();
        test_reset_mid();
        test_random();
`ifdef UART_ARB_LOCK_EN
        test_lock();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete by %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
